// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and types for the Gray switch interface (tx and decoder sides).
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;
  localparam int GRAY_MAX_W         = 32;

  typedef enum logic {IDLE, HOLD} gray_tx_state_t;

  // Callers zero-extend to GRAY_MAX_W and truncate the result back to their width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic int unsigned gray_popcount(input logic [GRAY_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gray_tx_if.sv
// Handshake and Gray output bundle between the stimulus side (master) and gray_tx (slave).
interface gray_tx_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] bin_in;
  logic             bin_valid;
  logic             bin_ready;
  logic [WIDTH-1:0] gray_out;
  logic             gray_strobe;
  logic             step_err;

  modport master (
    output bin_in, bin_valid,
    input  bin_ready, gray_out, gray_strobe, step_err
  );

  modport slave (
    input  bin_in, bin_valid,
    output bin_ready, gray_out, gray_strobe, step_err
  );
endinterface

// File: rtl/gray_hold_timer.sv
// Hold-time counter: loads HOLD_CYCLES-1 on load, counts down to 0, done while at 0.
module gray_hold_timer
  import gray_pkg::*;
#(
  parameter int HOLD_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  if (HOLD_CYCLES > 1) begin : g_cnt
    localparam int CW = $clog2(HOLD_CYCLES);
    logic [CW-1:0] cnt;

    // Counter idles at 0 outside HOLD, so it can free-run down without an enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            cnt <= '0;
      else if (load)         cnt <= CW'(HOLD_CYCLES - 1);
      else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);
  end else begin : g_nocnt
    wire unused_ok = &{1'b0, clk, rst_n, load};
    assign done = 1'b1;
  end

endmodule

// File: rtl/gray_tx.sv
// Gray-code transmitter: accepts binary over valid/ready, holds Gray value HOLD_CYCLES clocks.
// Optional GRAY_STEP_CHECK_EN builds a sticky non-adjacent-step detector on step_err.
module gray_tx
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_WIDTH_DEFAULT,
  parameter int HOLD_CYCLES = 3
) (
  input logic       clk,
  input logic       rst_n,
  gray_tx_if.slave  bus
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("gray_tx: HOLD_CYCLES must be >= 1");
  end
  if (WIDTH < 1 || WIDTH > GRAY_MAX_W) begin : g_bad_width
    $error("gray_tx: WIDTH out of range");
  end

  gray_tx_state_t   state;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_next;
  logic             accept;
  logic             done;

  assign accept    = (state == IDLE) && bus.bin_valid;
  assign gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(bus.bin_in)));

  gray_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gray_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.bin_valid) begin
          gray_q <= gray_next;
          state  <= HOLD;
        end
        HOLD: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic step_err_q;

  // Compare against the value currently on the wire, i.e. the previous accepted code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step_err_q <= 1'b0;
    else if (accept && gray_popcount(GRAY_MAX_W'(gray_next ^ gray_q)) > 1)
      step_err_q <= 1'b1;
  end

  assign bus.step_err = step_err_q;
`else
  assign bus.step_err = 1'b0;
`endif

  assign bus.bin_ready   = (state == IDLE);
  assign bus.gray_out    = gray_q;
  assign bus.gray_strobe = (state == HOLD) && done;

endmodule
